// File: rtl/ball_motion_engine.sv
// Per-ball fixed-point motion generator: friction with low-speed smoothing, cushion
// reflection, collision rollback and pocket/respawn. Define CUSHION_DAMP_EN for lossy cushions.
//   state    | meaning
//   STOPPED  | on table, velocity zero, accepts strikes
//   ROLLING  | advancing once per frame, cushions active
//   POCKETED | hidden and frozen until respawn
module ball_motion_engine #(
    parameter int POS_W         = 11,
    parameter int VEL_W         = 12,
    parameter int FRAC_BITS     = 6,
    parameter int TABLE_X       = 60,
    parameter int TABLE_Y       = 90,
    parameter int TABLE_W       = 520,
    parameter int TABLE_H       = 270,
    parameter int WOOD_W        = 20,
    parameter int BALL_SIZE     = 16,
    parameter int INIT_X        = 100,
    parameter int INIT_Y        = 207,
    parameter int RESPAWN_X     = 100,
    parameter int RESPAWN_Y     = 207,
    parameter int FRICTION      = 1,
    parameter int SLOW_LIM      = 25,
    parameter int SMOOTH_FRAMES = 2,
    parameter int V_MAX         = 1023,
    parameter int DAMP_SHIFT    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_of_frame,
    input  logic                    strike,
    input  logic signed [VEL_W-1:0] strike_vx,
    input  logic signed [VEL_W-1:0] strike_vy,
    input  logic                    collision,
    input  logic signed [VEL_W-1:0] collision_vx,
    input  logic signed [VEL_W-1:0] collision_vy,
    input  logic                    scored,
    input  logic                    respawn,
    output logic [POS_W-1:0]        top_left_x,
    output logic [POS_W-1:0]        top_left_y,
    output logic signed [VEL_W-1:0] velocity_x,
    output logic signed [VEL_W-1:0] velocity_y,
    output logic                    moving,
    output logic                    visible,
    output logic                    bounce
);
    localparam int PW  = POS_W + FRAC_BITS + 1;
    localparam int PXW = PW - FRAC_BITS;
    localparam int CW  = $clog2(SMOOTH_FRAMES + 2);

    typedef logic signed [PW-1:0]    pos_t;
    typedef logic signed [PXW-1:0]   pix_t;
    typedef logic signed [VEL_W-1:0] vel_t;
    typedef logic [CW-1:0]           cnt_t;
    typedef enum logic [1:0] {STOPPED, ROLLING, POCKETED} ballState_t;

`ifdef CUSHION_DAMP_EN
    localparam bit DAMP_ON = 1'b1;
`else
    localparam bit DAMP_ON = 1'b0;
`endif

    localparam pix_t X_LO = pix_t'(TABLE_X + WOOD_W);
    localparam pix_t X_HI = pix_t'(TABLE_X + TABLE_W - WOOD_W - BALL_SIZE);
    localparam pix_t Y_LO = pix_t'(TABLE_Y + WOOD_W);
    localparam pix_t Y_HI = pix_t'(TABLE_Y + TABLE_H - WOOD_W - BALL_SIZE);
    localparam pos_t FX_LO   = pos_t'((TABLE_X + WOOD_W) * (2 ** FRAC_BITS));
    localparam pos_t FX_HI   = pos_t'((TABLE_X + TABLE_W - WOOD_W - BALL_SIZE) * (2 ** FRAC_BITS));
    localparam pos_t FY_LO   = pos_t'((TABLE_Y + WOOD_W) * (2 ** FRAC_BITS));
    localparam pos_t FY_HI   = pos_t'((TABLE_Y + TABLE_H - WOOD_W - BALL_SIZE) * (2 ** FRAC_BITS));
    localparam pos_t FX_INIT = pos_t'(INIT_X * (2 ** FRAC_BITS));
    localparam pos_t FY_INIT = pos_t'(INIT_Y * (2 ** FRAC_BITS));
    localparam pos_t FX_RESP = pos_t'(RESPAWN_X * (2 ** FRAC_BITS));
    localparam pos_t FY_RESP = pos_t'(RESPAWN_Y * (2 ** FRAC_BITS));
    localparam vel_t VMAX    = vel_t'(V_MAX);
    localparam vel_t FRIC    = vel_t'(FRICTION);
    localparam vel_t SLOW    = vel_t'(SLOW_LIM);
    localparam cnt_t SMOOTH  = cnt_t'(SMOOTH_FRAMES);

    ballState_t state, stateN;
    pos_t posX, posY, savedX, savedY, posXN, posYN, savedXN, savedYN;
    vel_t velX, velY, velXN, velYN;
    cnt_t cntX, cntY, cntXN, cntYN;
    logic bounceR, bounceN;
    pix_t pixX, pixY;
    logic hitXLo, hitXHi, hitYLo, hitYHi;

    function automatic vel_t saturate(input vel_t v);
        if (v > VMAX) return VMAX;
        if (v < -VMAX) return -VMAX;
        return v;
    endfunction

    function automatic vel_t reflect(input vel_t v);
        vel_t mag;
        mag = v[VEL_W-1] ? -v : v;
        mag = mag - (DAMP_ON ? (mag >>> DAMP_SHIFT) : '0);
        return v[VEL_W-1] ? mag : -mag;
    endfunction

    function automatic logic isFast(input vel_t v);
        return (v >= SLOW) || (v <= -SLOW);
    endfunction

    function automatic logic decDue(input vel_t v, input cnt_t c);
        return (v != '0) && (isFast(v) || (c == SMOOTH));
    endfunction

    function automatic cnt_t nextCount(input vel_t v, input cnt_t c);
        if (v == '0) return '0;
        if (isFast(v)) return c;
        if (c == SMOOTH) return '0;
        return c + 1'b1;
    endfunction

    // Friction moves toward zero but never past it.
    function automatic vel_t decMag(input vel_t v);
        if (!v[VEL_W-1]) return (v > FRIC) ? v - FRIC : '0;
        return (v < -FRIC) ? v + FRIC : '0;
    endfunction

    function automatic pos_t extend(input vel_t v);
        return {{(PW-VEL_W){v[VEL_W-1]}}, v};
    endfunction

    assign pixX   = posX[PW-1:FRAC_BITS];
    assign pixY   = posY[PW-1:FRAC_BITS];
    assign hitXLo = (state == ROLLING) && (pixX <= X_LO) && velX[VEL_W-1];
    assign hitXHi = (state == ROLLING) && (pixX >= X_HI) && !velX[VEL_W-1] && (velX != '0);
    assign hitYLo = (state == ROLLING) && (pixY <= Y_LO) && velY[VEL_W-1];
    assign hitYHi = (state == ROLLING) && (pixY >= Y_HI) && !velY[VEL_W-1] && (velY != '0);

    always_comb begin
        stateN  = state;
        posXN   = posX;
        posYN   = posY;
        savedXN = savedX;
        savedYN = savedY;
        velXN   = velX;
        velYN   = velY;
        cntXN   = cntX;
        cntYN   = cntY;
        bounceN = 1'b0;
        if (scored) begin
            stateN = POCKETED;
            velXN  = '0;
            velYN  = '0;
        end else if (respawn && (state == POCKETED)) begin
            stateN  = STOPPED;
            posXN   = FX_RESP;
            posYN   = FY_RESP;
            savedXN = FX_RESP;
            savedYN = FY_RESP;
            cntXN   = '0;
            cntYN   = '0;
        end else if (hitXLo || hitXHi || hitYLo || hitYHi) begin
            if (hitXLo || hitXHi) begin
                velXN = reflect(velX);
                posXN = hitXLo ? FX_LO : FX_HI;
            end
            if (hitYLo || hitYHi) begin
                velYN = reflect(velY);
                posYN = hitYLo ? FY_LO : FY_HI;
            end
            bounceN = 1'b1;
        end else if (strike && (state == STOPPED)) begin
            velXN = saturate(strike_vx);
            velYN = saturate(strike_vy);
            if ((velXN != '0) || (velYN != '0)) stateN = ROLLING;
        end else if (collision && (state != POCKETED)) begin
            posXN = savedX;
            posYN = savedY;
            velXN = saturate(collision_vx);
            velYN = saturate(collision_vy);
            if ((state == STOPPED) && ((velXN != '0) || (velYN != '0))) stateN = ROLLING;
        end else if (start_of_frame && (state == ROLLING)) begin
            savedXN = posX;
            savedYN = posY;
            posXN   = posX + extend(velX);
            posYN   = posY + extend(velY);
            velXN   = decDue(velX, cntX) ? decMag(velX) : velX;
            velYN   = decDue(velY, cntY) ? decMag(velY) : velY;
            cntXN   = nextCount(velX, cntX);
            cntYN   = nextCount(velY, cntY);
            if ((velXN == '0) && (velYN == '0)) stateN = STOPPED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= STOPPED;
            posX    <= FX_INIT;
            posY    <= FY_INIT;
            savedX  <= FX_INIT;
            savedY  <= FY_INIT;
            velX    <= '0;
            velY    <= '0;
            cntX    <= '0;
            cntY    <= '0;
            bounceR <= 1'b0;
        end else begin
            state   <= stateN;
            posX    <= posXN;
            posY    <= posYN;
            savedX  <= savedXN;
            savedY  <= savedYN;
            velX    <= velXN;
            velY    <= velYN;
            cntX    <= cntXN;
            cntY    <= cntYN;
            bounceR <= bounceN;
        end
    end

    assign top_left_x = posX[FRAC_BITS +: POS_W];
    assign top_left_y = posY[FRAC_BITS +: POS_W];
    assign velocity_x = velX;
    assign velocity_y = velY;
    assign moving     = (state == ROLLING);
    assign visible    = (state != POCKETED);
    assign bounce     = bounceR;
endmodule
